// File: rtl/mips_pkg.sv
// Shared encodings and control decode for the MIPS execute slice.
// Holds opcode/funct constants, ALU codes and the per-instruction control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       reg_wr_en;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_wr_en;
        logic       branch;
        logic       jump;
        logic [2:0] alu_ctrl;
    } ctrl_t;

    // Unknown opcodes and unknown R-type functs leave every write disabled.
    function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
        ctrl_t c;
        c          = '0;
        c.alu_ctrl = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                c.reg_wr_en = 1'b1;
                c.reg_dst   = 1'b1;
                case (funct)
                    FUNCT_ADD: c.alu_ctrl = ALU_ADD;
                    FUNCT_SUB: c.alu_ctrl = ALU_SUB;
                    FUNCT_AND: c.alu_ctrl = ALU_AND;
                    FUNCT_OR:  c.alu_ctrl = ALU_OR;
                    FUNCT_SLT: c.alu_ctrl = ALU_SLT;
                    default:   c.reg_wr_en = 1'b0;
                endcase
            end
            OP_LW: begin
                c.reg_wr_en  = 1'b1;
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_wr_en = 1'b1;
            end
            OP_BEQ: begin
                c.branch   = 1'b1;
                c.alu_ctrl = ALU_SUB;
            end
            OP_ADDI: begin
                c.reg_wr_en = 1'b1;
                c.alu_src   = 1'b1;
            end
            OP_J:    c.jump = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 2-read / 1-write register file with register 0 hardwired to zero.
// Reads are asynchronous with no bypass; reset clears every entry on the edge.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH_P = 32,
    parameter int ADDR_WIDTH_P = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH_P-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH_P-1:0] rd_addr_b,
    output logic [DATA_WIDTH_P-1:0] rd_data_a,
    output logic [DATA_WIDTH_P-1:0] rd_data_b,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH_P-1:0] wr_addr,
    input  logic [DATA_WIDTH_P-1:0] wr_data
);

    logic [DATA_WIDTH_P-1:0] regs [2**ADDR_WIDTH_P];

    // NOTE: the register array is cleared by reset because software relies on
    // zeroed registers; non-blocking updates keep reads same-edge consistent.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**ADDR_WIDTH_P; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/mips_exec_unit.sv
// Single-cycle MIPS execute slice: control decode, register file and ALU.
// All outputs are combinational from i_instr; only register writes are clocked.
module mips_exec_unit
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH_P      = 32,
    parameter int ADDR_WIDTH_P      = 5,
    parameter int ALU_CNTRL_WIDTH_P = 3,
    parameter int OP_WIDTH_P        = 6,
    parameter int FUNCT_WIDTH_P     = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             i_instr,
    input  logic [DATA_WIDTH_P-1:0] i_mem_rd_data,
    output logic [DATA_WIDTH_P-1:0] o_alu_result,
    output logic                    o_zero,
    output logic                    o_mem_wr_en,
    output logic [DATA_WIDTH_P-1:0] o_mem_wr_data,
    output logic                    o_branch,
    output logic                    o_jump,
    output logic [DATA_WIDTH_P-1:0] o_sign_imm
);

    logic [OP_WIDTH_P-1:0]        op;
    logic [FUNCT_WIDTH_P-1:0]     funct;
    logic [ADDR_WIDTH_P-1:0]      rs;
    logic [ADDR_WIDTH_P-1:0]      rt;
    logic [ADDR_WIDTH_P-1:0]      rd;
    logic [15:0]                  imm;
    ctrl_t                        ctrl;
    logic [ALU_CNTRL_WIDTH_P-1:0] alu_ctrl;
    logic [DATA_WIDTH_P-1:0]      rs_data;
    logic [DATA_WIDTH_P-1:0]      rt_data;
    logic [DATA_WIDTH_P-1:0]      alu_b;
    logic [ADDR_WIDTH_P-1:0]      wr_addr;
    logic [DATA_WIDTH_P-1:0]      wr_data;

    assign op    = i_instr[31 -: OP_WIDTH_P];
    assign funct = i_instr[FUNCT_WIDTH_P-1:0];
    assign rs    = i_instr[25 -: ADDR_WIDTH_P];
    assign rt    = i_instr[20 -: ADDR_WIDTH_P];
    assign rd    = i_instr[15 -: ADDR_WIDTH_P];
    assign imm   = i_instr[15:0];

    assign ctrl     = decode_ctrl(op, funct);
    assign alu_ctrl = ctrl.alu_ctrl;

    assign o_sign_imm = {{(DATA_WIDTH_P-16){imm[15]}}, imm};
    assign alu_b      = ctrl.alu_src ? o_sign_imm : rt_data;

    // NOTE: result gets a default first so no path through the case infers a latch.
    always_comb begin
        o_alu_result = '0;
        case (alu_ctrl)
            ALU_AND: o_alu_result = rs_data & alu_b;
            ALU_OR:  o_alu_result = rs_data | alu_b;
            ALU_ADD: o_alu_result = rs_data + alu_b;
            ALU_SUB: o_alu_result = rs_data - alu_b;
            ALU_SLT: o_alu_result = {{(DATA_WIDTH_P-1){1'b0}}, ($signed(rs_data) < $signed(alu_b))};
            default: o_alu_result = '0;
        endcase
    end

    assign o_zero        = (o_alu_result == '0);
    assign o_mem_wr_en   = ctrl.mem_wr_en;
    assign o_mem_wr_data = rt_data;
    assign o_branch      = ctrl.branch;
    assign o_jump        = ctrl.jump;

    assign wr_addr = ctrl.reg_dst ? rd : rt;
    assign wr_data = ctrl.mem_to_reg ? i_mem_rd_data : o_alu_result;

    mips_regfile #(
        .DATA_WIDTH_P(DATA_WIDTH_P),
        .ADDR_WIDTH_P(ADDR_WIDTH_P)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rd_addr_a(rs),
        .rd_addr_b(rt),
        .rd_data_a(rs_data),
        .rd_data_b(rt_data),
        .wr_en    (ctrl.reg_wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

endmodule

// File: tb/tb_mips_exec_unit.sv
// Directed bench for mips_exec_unit: expectations are queued per step and
// compared against the combinational outputs before the next rising edge.
module tb_mips_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] mem_rd_data;
    logic [31:0] alu_result;
    logic        zero;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic        branch;
    logic        jump;
    logic [31:0] sign_imm;

    mips_exec_unit dut (
        .clk          (clk),
        .reset        (reset),
        .i_instr      (instr),
        .i_mem_rd_data(mem_rd_data),
        .o_alu_result (alu_result),
        .o_zero       (zero),
        .o_mem_wr_en  (mem_wr_en),
        .o_mem_wr_data(mem_wr_data),
        .o_branch     (branch),
        .o_jump       (jump),
        .o_sign_imm   (sign_imm)
    );

    always #5 clk = ~clk;

    typedef enum {S_ALU, S_ZERO, S_WREN, S_WDATA, S_BR, S_JMP, S_SIMM} sel_e;
    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [31:0] observe(input sel_e s);
        case (s)
            S_ALU:   return alu_result;
            S_ZERO:  return {31'd0, zero};
            S_WREN:  return {31'd0, mem_wr_en};
            S_WDATA: return mem_wr_data;
            S_BR:    return {31'd0, branch};
            S_JMP:   return {31'd0, jump};
            default: return sign_imm;
        endcase
    endfunction

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int funct);
        logic [31:0] w;
        w = {6'b000000, rs[4:0], rt[4:0], rd[4:0], 5'd0, funct[5:0]};
        return w;
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
        logic [31:0] w;
        w = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
        return w;
    endfunction

    task automatic push(input string tag, input sel_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.sel);
            n_total++;
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.exp);
        end
    endtask

    // Drive on the falling edge, compare mid-cycle, then let the rising edge commit.
    task automatic step(input logic [31:0] ins, input logic [31:0] rd_word);
        instr       = ins;
        mem_rd_data = rd_word;
        #2;
        drain();
        @(posedge clk);
        @(negedge clk);
    endtask

    // sw $r,0($0) exposes rt data on o_mem_wr_data without touching registers.
    task automatic read_reg(input string tag, input int r, input logic [31:0] v);
        push(tag, S_WDATA, v);
        step(i_ins(6'b101011, 0, r, 0), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        instr       = r_ins(1, 2, 3, 6'b100000);
        mem_rd_data = 32'd0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        push("rst_add_alu", S_ALU, 32'd0);
        push("rst_add_zero", S_ZERO, 32'd1);
        push("rst_add_wren", S_WREN, 32'd0);
        step(r_ins(1, 2, 3, 6'b100000), 32'd0);
        read_reg("rst_r1", 1, 32'd0);
        read_reg("rst_r31", 31, 32'd0);

        push("addi_r8_alu", S_ALU, 32'd5);
        push("addi_r8_simm", S_SIMM, 32'd5);
        push("addi_r8_zero", S_ZERO, 32'd0);
        step(i_ins(6'b001000, 0, 8, 5), 32'd0);

        push("add_r9_alu", S_ALU, 32'd10);
        step(r_ins(8, 8, 9, 6'b100000), 32'd0);
        read_reg("r9_after_add", 9, 32'd10);
        read_reg("r8_after_addi", 8, 32'd5);

        push("sub_alu", S_ALU, 32'd0);
        push("sub_zero", S_ZERO, 32'd1);
        step(r_ins(8, 8, 10, 6'b100010), 32'd0);

        push("addi_neg_alu", S_ALU, 32'hFFFF_FFFF);
        push("addi_neg_simm", S_SIMM, 32'hFFFF_FFFF);
        step(i_ins(6'b001000, 0, 11, 16'hFFFF), 32'd0);

        push("slt_neg_lt_pos", S_ALU, 32'd1);
        step(r_ins(11, 8, 12, 6'b101010), 32'd0);
        push("slt_pos_lt_neg", S_ALU, 32'd0);
        push("slt_pos_zero", S_ZERO, 32'd1);
        step(r_ins(8, 11, 19, 6'b101010), 32'd0);
        read_reg("r12_slt", 12, 32'd1);

        step(i_ins(6'b001000, 0, 14, 16'h00F0), 32'd0);
        step(i_ins(6'b001000, 0, 15, 16'h003C), 32'd0);
        push("and_alu", S_ALU, 32'h30);
        step(r_ins(14, 15, 16, 6'b100100), 32'd0);
        push("or_alu", S_ALU, 32'hFC);
        step(r_ins(14, 15, 17, 6'b100101), 32'd0);
        read_reg("r16_and", 16, 32'h30);
        read_reg("r17_or", 17, 32'hFC);

        push("lw_addr", S_ALU, 32'd9);
        push("lw_wren", S_WREN, 32'd0);
        step(i_ins(6'b100011, 8, 13, 4), 32'hDEAD_BEEF);
        read_reg("r13_lw", 13, 32'hDEAD_BEEF);

        push("sw_wren", S_WREN, 32'd1);
        push("sw_addr", S_ALU, 32'd8);
        push("sw_wdata", S_WDATA, 32'd5);
        step(i_ins(6'b101011, 0, 8, 8), 32'h1234_5678);
        read_reg("r8_after_sw", 8, 32'd5);

        push("beq_branch", S_BR, 32'd1);
        push("beq_zero", S_ZERO, 32'd1);
        push("beq_simm", S_SIMM, 32'hFFFF_FFFF);
        push("beq_jump", S_JMP, 32'd0);
        push("beq_wren", S_WREN, 32'd0);
        step(i_ins(6'b000100, 8, 8, 16'hFFFF), 32'd0);

        push("j_jump", S_JMP, 32'd1);
        push("j_branch", S_BR, 32'd0);
        push("j_wren", S_WREN, 32'd0);
        step({6'b000010, 26'h000_0100}, 32'd0);
        push("j_fields_jump", S_JMP, 32'd1);
        step({6'b000010, 26'h108_0000}, 32'd0);
        read_reg("r8_after_j", 8, 32'd5);

        push("addi_r0_alu", S_ALU, 32'd7);
        step(i_ins(6'b001000, 0, 0, 7), 32'd0);
        read_reg("r0_stays_zero", 0, 32'd0);

        push("badop_alu", S_ALU, 32'd15);
        push("badop_wren", S_WREN, 32'd0);
        push("badop_branch", S_BR, 32'd0);
        push("badop_jump", S_JMP, 32'd0);
        step(i_ins(6'b111111, 8, 9, 0), 32'd0);
        read_reg("r9_after_badop", 9, 32'd10);

        push("badfunct_alu", S_ALU, 32'd10);
        push("badfunct_wren", S_WREN, 32'd0);
        step(r_ins(8, 8, 18, 6'b000111), 32'd0);
        read_reg("r18_after_badfunct", 18, 32'd0);

        reset = 1'b1;
        push("reset_mid_alu", S_ALU, 32'd1);
        step(i_ins(6'b001000, 0, 20, 1), 32'd0);
        reset = 1'b0;
        read_reg("r9_after_reset", 9, 32'd0);
        read_reg("r8_after_reset", 8, 32'd0);
        read_reg("r13_after_reset", 13, 32'd0);
        read_reg("r20_write_suppressed", 20, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
